lif_ring_reservoir: RTL

Parametrised reservoir of N leaky integrate-and-fire neurons in a unidirectional ring, driven by a shared external input current. It succeeds the fixed ten-neuron hand-wired ring used with the NARMA system. It adds:
- configurable neuron count, widths and dynamics;
- refractory periods;
- saturating membrane arithmetic;
- a kick input to seed ring activity;
- optional windowed spike counters for the readout stage.

---
 rtl/lif_res_pkg.sv | 30 +++
 rtl/lif_cell.sv | 72 +++++++
 rtl/lif_ring_reservoir.sv | 111 +++++++++++
 3 files changed

// File: rtl/lif_res_pkg.sv
// Shared types and helpers for the LIF ring reservoir.
// Membrane values are Q.10 fixed point.
package lif_res_pkg;

    localparam int Q_FRAC = 10;

    typedef struct packed {
        logic signed [63:0] v;
        logic [7:0]         refr_cnt;
        logic               spike;
    } lif_state_t;

    function automatic logic signed [63:0] sat(
        input logic signed [65:0] x,
        input int                 w
    );
        logic signed [65:0] hi;
        logic signed [65:0] lo;
        hi = (66'sd1 <<< (w - 1)) - 66'sd1;
        lo = -(66'sd1 <<< (w - 1));
        if (x > hi) begin
            return hi[63:0];
        end else if (x < lo) begin
            return lo[63:0];
        end else begin
            return x[63:0];
        end
    endfunction

endpackage

// File: rtl/lif_cell.sv
// One leaky integrate-and-fire neuron: leak, integrate,
// saturate, threshold and refractory hold.
module lif_cell
    import lif_res_pkg::*;
#(
    parameter int V_W        = 32,
    parameter int IN_W       = 32,
    parameter int THRESH     = 1024,
    parameter int V_RESET    = 0,
    parameter int W_SYN      = 1536,
    parameter int LEAK_SHIFT = 3,
    parameter int REFRACT    = 2
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   en_i,
    input  logic signed [IN_W-1:0] ext_i,
    input  logic                   syn_i,
    output logic                   spike_o,
    output logic                   fire_o,
    output logic [V_W-1:0]         v_o
);

    lif_state_t st_q, st_d;
    logic signed [65:0] v_ext, leak, syn_w, sum;
    logic signed [63:0] v_next;

    // Candidate membrane value and firing decision.
    always_comb begin
        v_ext  = 66'($signed(st_q.v));
        leak   = v_ext >>> LEAK_SHIFT;
        syn_w  = syn_i ? 66'(W_SYN) : '0;
        sum    = v_ext - leak + 66'(ext_i) + syn_w;
        v_next = sat(sum, V_W);
        fire_o = en_i && (st_q.refr_cnt == '0)
                 && (v_next >= 64'(THRESH));
    end

    // Next state: refractory hold, fire-and-reset, or integrate.
    always_comb begin
        st_d = st_q;
        if (en_i) begin
            if (st_q.refr_cnt != '0) begin
                st_d.v        = 64'(V_RESET);
                st_d.spike    = 1'b0;
                st_d.refr_cnt = st_q.refr_cnt - 8'd1;
            end else if (fire_o) begin
                st_d.v        = 64'(V_RESET);
                st_d.spike    = 1'b1;
                st_d.refr_cnt = 8'(REFRACT);
            end else begin
                st_d.v        = v_next;
                st_d.spike    = 1'b0;
            end
        end
    end

    // Neuron state register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            st_q.v        <= 64'(V_RESET);
            st_q.refr_cnt <= '0;
            st_q.spike    <= 1'b0;
        end else begin
            st_q <= st_d;
        end
    end

    assign spike_o = st_q.spike;
    assign v_o     = st_q.v[V_W-1:0];

endmodule

// File: rtl/lif_ring_reservoir.sv
// Ring of LIF neurons with kick seeding and, when
// RES_WINDOW_COUNT_EN is defined, windowed spike counters.
module lif_ring_reservoir
    import lif_res_pkg::*;
#(
    parameter int N_NEURONS  = 10,
    parameter int V_W        = 32,
    parameter int IN_W       = 32,
    parameter int THRESH     = 1 << Q_FRAC,
    parameter int V_RESET    = 0,
    parameter int W_SYN      = 3 << (Q_FRAC - 1),
    parameter int LEAK_SHIFT = 3,
    parameter int REFRACT    = 2,
    parameter int WIN_LEN    = 16,
    parameter int CNT_W      = $clog2(WIN_LEN + 1)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         en,
    input  logic signed [IN_W-1:0]       ext_input,
    input  logic                         kick,
    output logic [N_NEURONS-1:0]         spikes,
    output logic [N_NEURONS*V_W-1:0]     vout,
    output logic [N_NEURONS*CNT_W-1:0]   win_counts,
    output logic                         win_valid
);

    logic [N_NEURONS-1:0] syn;
    logic [N_NEURONS-1:0] fire;

    // Kick and the wrap-around spike merge into one event.
    assign syn = {spikes[N_NEURONS-2:0],
                  spikes[N_NEURONS-1] | kick};

    for (genvar gi = 0; gi < N_NEURONS; gi++) begin : g_cell
        lif_cell #(
            .V_W        (V_W),
            .IN_W       (IN_W),
            .THRESH     (THRESH),
            .V_RESET    (V_RESET),
            .W_SYN      (W_SYN),
            .LEAK_SHIFT (LEAK_SHIFT),
            .REFRACT    (REFRACT)
        ) u_cell (
            .clk_i   (clk),
            .rst_i   (rst),
            .en_i    (en),
            .ext_i   (ext_input),
            .syn_i   (syn[gi]),
            .spike_o (spikes[gi]),
            .fire_o  (fire[gi]),
            .v_o     (vout[gi*V_W +: V_W])
        );
    end

`ifdef RES_WINDOW_COUNT_EN
    localparam int WC_W = (WIN_LEN > 1) ? $clog2(WIN_LEN) : 1;

    logic [WC_W-1:0]                      win_ctr_q, win_ctr_d;
    logic [N_NEURONS-1:0][CNT_W-1:0]      run_q, run_d;
    logic [N_NEURONS-1:0][CNT_W-1:0]      cnt_q, cnt_d;
    logic                                 valid_q, valid_d;

    // Running counts, window wrap and count latch.
    always_comb begin
        win_ctr_d = win_ctr_q;
        run_d     = run_q;
        cnt_d     = cnt_q;
        valid_d   = 1'b0;
        if (en) begin
            for (int i = 0; i < N_NEURONS; i++) begin
                if (fire[i] && (run_q[i] != '1)) begin
                    run_d[i] = run_q[i] + 1'b1;
                end
            end
            if (win_ctr_q == WC_W'(WIN_LEN - 1)) begin
                cnt_d     = run_d;
                run_d     = '0;
                win_ctr_d = '0;
                valid_d   = 1'b1;
            end else begin
                win_ctr_d = win_ctr_q + 1'b1;
            end
        end
    end

    // Window counter state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            win_ctr_q <= '0;
            run_q     <= '0;
            cnt_q     <= '0;
            valid_q   <= 1'b0;
        end else begin
            win_ctr_q <= win_ctr_d;
            run_q     <= run_d;
            cnt_q     <= cnt_d;
            valid_q   <= valid_d;
        end
    end

    assign win_counts = cnt_q;
    assign win_valid  = valid_q;
`else
    logic unused_fire;
    assign unused_fire = ^fire;
    assign win_counts  = '0;
    assign win_valid   = 1'b0;
`endif

endmodule
